mem_responder: RTL and testbench

- Responder (slave) end of the core data-memory request interface: req/addr/addr_high/data/we/sel/long in; ack/data/exception out.
- Decodes each request, inserts configurable wait states and drives one single-port SRAM macro with byte-write mask.
- Returns read data with a one-cycle ack, or a one-cycle exception for out-of-range addresses.
- Sits between the core memory port and the on-chip data SRAM.

---
 rtl/mem_responder_pkg.sv | 17 +
 rtl/mem_responder.sv | 114 +++++++++++
 tb/tb_mem_responder.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// Shared widths and FSM state encoding for the data-memory responder and its SRAM wrapper.
package mem_responder_pkg;

  localparam int CFG_RW         = 16;
  localparam int CFG_ADDR_BYTES = 2;
  localparam int DMEM_AW        = 10;
  localparam int WAIT_CNT_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_ACK    = 3'd3,
    ST_EXC    = 3'd4
  } state_e;

endpackage

// File: rtl/mem_responder.sv
// Responder end of the core data-memory port: decodes a request, optionally waits,
// performs one SRAM cycle and answers with a single ack or exception pulse.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int RW          = CFG_RW,
  parameter int ADDR_BYTES  = CFG_ADDR_BYTES,
  parameter int SRAM_AW     = DMEM_AW,
  parameter int WAIT_STATES = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_mem_req,
  input  logic [RW-1:0]         i_mem_addr,
  input  logic [7:0]            i_mem_addr_high,
  input  logic                  i_mem_long,
  input  logic                  i_mem_we,
  input  logic [RW-1:0]         i_mem_data,
  input  logic [ADDR_BYTES-1:0] i_mem_sel,
  output logic                  o_mem_ack,
  output logic [RW-1:0]         o_mem_data,
  output logic                  o_mem_exception,
  output logic                  o_sram_en,
  output logic                  o_sram_we,
  output logic [ADDR_BYTES-1:0] o_sram_wmask,
  output logic [SRAM_AW-1:0]    o_sram_addr,
  output logic [RW-1:0]         o_sram_wdata,
  input  logic [RW-1:0]         i_sram_rdata
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
    (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  state_e                  state_q;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q;
  logic [SRAM_AW-1:0]      addr_q;
  logic [RW-1:0]           wdata_q;
  logic                    we_q;
  logic [ADDR_BYTES-1:0]   sel_q;
  logic                    ack_q;
  logic                    exc_q;
  logic                    sram_en_q;
  logic                    decode_err;

  // Anything outside the SRAM window, including any non-zero high byte on a long access.
  assign decode_err = (i_mem_long && (i_mem_addr_high != 8'h00)) ||
                      ((i_mem_addr >> SRAM_AW) != '0);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      ack_q      <= 1'b0;
      exc_q      <= 1'b0;
      sram_en_q  <= 1'b0;
    end else begin
      ack_q     <= 1'b0;
      exc_q     <= 1'b0;
      sram_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_mem_req) begin
            if (decode_err) begin
              state_q <= ST_EXC;
              exc_q   <= 1'b1;
            end else begin
              addr_q  <= i_mem_addr[SRAM_AW-1:0];
              wdata_q <= i_mem_data;
              we_q    <= i_mem_we;
              sel_q   <= i_mem_sel;
              if (WAIT_STATES == 0) begin
                state_q   <= ST_ACCESS;
                sram_en_q <= 1'b1;
              end else begin
                state_q    <= ST_WAIT;
                wait_cnt_q <= WAIT_INIT;
              end
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt_q == '0) begin
            state_q   <= ST_ACCESS;
            sram_en_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
        end
        ST_ACCESS: begin
          state_q <= ST_ACK;
          ack_q   <= 1'b1;
        end
        ST_ACK:  state_q <= ST_IDLE;
        ST_EXC:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_mem_ack       = ack_q;
  assign o_mem_exception = exc_q;
  assign o_sram_en       = sram_en_q;
  assign o_sram_we       = sram_en_q & we_q;
  assign o_sram_wmask    = sram_en_q ? sel_q : '0;
  assign o_sram_addr     = addr_q;
  assign o_sram_wdata    = wdata_q;
  // SRAM data arrives the cycle after en, which is exactly the ack cycle.
  assign o_mem_data      = (ack_q && !we_q) ? i_sram_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance without and one with wait states,
// each backed by a simple byte-masked SRAM model.
module tb_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        req0, req3;
  logic [15:0] addr, data;
  logic [7:0]  ah;
  logic        lng, we;
  logic [1:0]  sel;

  logic        ack0, exc0, en0, swe0;
  logic [1:0]  wm0;
  logic [9:0]  sa0;
  logic [15:0] swd0, rd0, md0;
  logic        ack3, exc3, en3, swe3;
  logic [1:0]  wm3;
  logic [9:0]  sa3;
  logic [15:0] swd3, rd3, md3;

  logic [15:0] mem0 [1024];
  logic [15:0] mem3 [1024];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_responder #(.RW(16), .ADDR_BYTES(2), .SRAM_AW(10), .WAIT_STATES(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst_n), .i_mem_req(req0), .i_mem_addr(addr),
    .i_mem_addr_high(ah), .i_mem_long(lng), .i_mem_we(we), .i_mem_data(data),
    .i_mem_sel(sel), .o_mem_ack(ack0), .o_mem_data(md0), .o_mem_exception(exc0),
    .o_sram_en(en0), .o_sram_we(swe0), .o_sram_wmask(wm0), .o_sram_addr(sa0),
    .o_sram_wdata(swd0), .i_sram_rdata(rd0)
  );

  mem_responder #(.RW(16), .ADDR_BYTES(2), .SRAM_AW(10), .WAIT_STATES(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst_n), .i_mem_req(req3), .i_mem_addr(addr),
    .i_mem_addr_high(ah), .i_mem_long(lng), .i_mem_we(we), .i_mem_data(data),
    .i_mem_sel(sel), .o_mem_ack(ack3), .o_mem_data(md3), .o_mem_exception(exc3),
    .o_sram_en(en3), .o_sram_we(swe3), .o_sram_wmask(wm3), .o_sram_addr(sa3),
    .o_sram_wdata(swd3), .i_sram_rdata(rd3)
  );

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem0[i] = 16'h0000;
      mem3[i] = 16'h0000;
    end
  end

  always @(posedge clk) begin
    if (en0) begin
      rd0 <= mem0[sa0];
      if (swe0) begin
        if (wm0[0]) mem0[sa0][7:0]  <= swd0[7:0];
        if (wm0[1]) mem0[sa0][15:8] <= swd0[15:8];
      end
    end
  end

  always @(posedge clk) begin
    if (en3) begin
      rd3 <= mem3[sa3];
      if (swe3) begin
        if (wm3[0]) mem3[sa3][7:0]  <= swd3[7:0];
        if (wm3[1]) mem3[sa3][15:8] <= swd3[15:8];
      end
    end
  end

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  ah;
    logic        lng;
    logic [15:0] data;
    logic [1:0]  sel;
    bit          exp_exc;
    int          exp_lat;
    logic [15:0] exp_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents one request, drops req when ack/exception is seen, records what happened.
  task automatic run_req(input bit d3, input vec_t v, input bit toggle,
                         output int lat, output bit exc, output logic [15:0] rdat,
                         output int en_cnt, output logic [9:0] en_addr,
                         output logic [1:0] en_mask, output logic en_we, output bit both);
    logic a, e, en;
    @(negedge clk);
    we = v.we; addr = v.addr; ah = v.ah; lng = v.lng; data = v.data; sel = v.sel;
    if (d3) req3 = 1'b1; else req0 = 1'b1;
    lat = -1; exc = 1'b0; rdat = '0; en_cnt = 0; en_addr = '0; en_mask = '0;
    en_we = 1'b0; both = 1'b0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      a  = d3 ? ack3 : ack0;
      e  = d3 ? exc3 : exc0;
      en = d3 ? en3  : en0;
      if (a && e) both = 1'b1;
      if (en) begin
        en_cnt++;
        en_addr = d3 ? sa3 : sa0;
        en_mask = d3 ? wm3 : wm0;
        en_we   = d3 ? swe3 : swe0;
      end
      if (a || e) begin
        lat  = k;
        exc  = e;
        rdat = d3 ? md3 : md0;
        req0 = 1'b0;
        req3 = 1'b0;
      end
      if (toggle && k == 2) begin
        addr = addr ^ 16'h0041; we = ~we; data = ~data; sel = ~sel;
      end
    end
  endtask

  vec_t        vecs [12];
  vec_t        v;
  int          lat, en_cnt, acks, first;
  bit          exc, both;
  logic [15:0] rdat;
  logic [9:0]  en_addr;
  logic [1:0]  en_mask;
  logic        en_we;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    //           we    addr      ah     lng   data      sel    exc  lat rdata
    vecs[0]  = '{1'b1, 16'h0012, 8'h00, 1'b0, 16'hBEEF, 2'b11, 1'b0, 2, 16'h0000};
    vecs[1]  = '{1'b0, 16'h0012, 8'h00, 1'b0, 16'h0000, 2'b11, 1'b0, 2, 16'hBEEF};
    vecs[2]  = '{1'b1, 16'h0012, 8'h00, 1'b0, 16'h5500, 2'b10, 1'b0, 2, 16'h0000};
    vecs[3]  = '{1'b0, 16'h0012, 8'h00, 1'b0, 16'h0000, 2'b11, 1'b0, 2, 16'h55EF};
    vecs[4]  = '{1'b0, 16'h0012, 8'h01, 1'b1, 16'h0000, 2'b11, 1'b1, 1, 16'h0000};
    vecs[5]  = '{1'b0, 16'h0400, 8'h00, 1'b0, 16'h0000, 2'b11, 1'b1, 1, 16'h0000};
    vecs[6]  = '{1'b1, 16'h03FF, 8'h00, 1'b0, 16'h1234, 2'b11, 1'b0, 2, 16'h0000};
    vecs[7]  = '{1'b0, 16'h03FF, 8'h00, 1'b0, 16'h0000, 2'b01, 1'b0, 2, 16'h1234};
    vecs[8]  = '{1'b1, 16'h0012, 8'h00, 1'b0, 16'hFFFF, 2'b00, 1'b0, 2, 16'h0000};
    vecs[9]  = '{1'b0, 16'h0012, 8'h00, 1'b0, 16'h0000, 2'b11, 1'b0, 2, 16'h55EF};
    vecs[10] = '{1'b0, 16'h0005, 8'h00, 1'b1, 16'h0000, 2'b11, 1'b0, 2, 16'h0000};
    vecs[11] = '{1'b1, 16'hFFFF, 8'h00, 1'b0, 16'hAAAA, 2'b11, 1'b1, 1, 16'h0000};

    rst_n = 1'b0; req0 = 1'b0; req3 = 1'b0;
    addr = '0; data = '0; ah = '0; lng = 1'b0; we = 1'b0; sel = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack0", {31'd0, ack0}, 0);
    chk("rst_exc0", {31'd0, exc0}, 0);
    chk("rst_en0",  {31'd0, en0}, 0);
    chk("rst_we0",  {31'd0, swe0}, 0);
    chk("rst_wm0",  {30'd0, wm0}, 0);
    chk("rst_sa0",  {22'd0, sa0}, 0);
    chk("rst_wd0",  {16'd0, swd0}, 0);
    chk("rst_md0",  {16'd0, md0}, 0);
    chk("rst_en3",  {31'd0, en3}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      run_req(1'b0, v, 1'b0, lat, exc, rdat, en_cnt, en_addr, en_mask, en_we, both);
      $display("vec %0d: we=%0b addr=%h lat=%0d exc=%0b rdata=%h en_cnt=%0d mask=%b",
               i, v.we, v.addr, lat, exc, rdat, en_cnt, en_mask);
      chk($sformatf("v%0d_lat", i), lat, v.exp_lat);
      chk($sformatf("v%0d_exc", i), {31'd0, exc}, {31'd0, v.exp_exc});
      chk($sformatf("v%0d_both", i), {31'd0, both}, 0);
      chk($sformatf("v%0d_data", i), {16'd0, rdat}, {16'd0, v.exp_rdata});
      chk($sformatf("v%0d_encnt", i), en_cnt, v.exp_exc ? 0 : 1);
      if (!v.exp_exc) begin
        chk($sformatf("v%0d_addr", i), {22'd0, en_addr}, {22'd0, v.addr[9:0]});
        chk($sformatf("v%0d_mask", i), {30'd0, en_mask}, {30'd0, v.sel});
        chk($sformatf("v%0d_we", i), {31'd0, en_we}, {31'd0, v.we});
      end
    end

    // Wait-state instance: write, then read with the request lines scrambled mid-wait.
    v = '{1'b1, 16'h0012, 8'h00, 1'b0, 16'hA5A5, 2'b11, 1'b0, 5, 16'h0000};
    run_req(1'b1, v, 1'b0, lat, exc, rdat, en_cnt, en_addr, en_mask, en_we, both);
    $display("ws3 write: lat=%0d en_cnt=%0d", lat, en_cnt);
    chk("ws3_wr_lat", lat, 5);
    chk("ws3_wr_encnt", en_cnt, 1);
    v = '{1'b0, 16'h0012, 8'h00, 1'b0, 16'h0000, 2'b11, 1'b0, 5, 16'hA5A5};
    run_req(1'b1, v, 1'b1, lat, exc, rdat, en_cnt, en_addr, en_mask, en_we, both);
    $display("ws3 toggled read: lat=%0d addr=%h rdata=%h we=%0b", lat, en_addr, rdat, en_we);
    chk("ws3_rd_lat", lat, 5);
    chk("ws3_rd_addr", {22'd0, en_addr}, 32'h012);
    chk("ws3_rd_we", {31'd0, en_we}, 0);
    chk("ws3_rd_mask", {30'd0, en_mask}, 32'h3);
    chk("ws3_rd_data", {16'd0, rdat}, 32'hA5A5);

    // Back-to-back: next read presented in the ack cycle with req held high.
    @(negedge clk);
    addr = 16'h03FF; we = 1'b0; lng = 1'b0; ah = 8'h00; sel = 2'b11; req0 = 1'b1;
    first = -1;
    for (int k = 1; k <= 10 && first < 0; k++) begin
      @(negedge clk);
      if (ack0) first = k;
    end
    chk("b2b_first_lat", first, 2);
    chk("b2b_first_data", {16'd0, md0}, 32'h1234);
    addr = 16'h0012;
    acks = 0; first = -1; rdat = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ack0) begin
        acks++;
        if (acks == 1) begin
          first = k; rdat = md0; req0 = 1'b0;
        end
      end
    end
    $display("b2b second: acks=%0d at=%0d rdata=%h", acks, first, rdat);
    chk("b2b_acks", acks, 1);
    chk("b2b_second_lat", first, 3);
    chk("b2b_second_data", {16'd0, rdat}, 32'h55EF);

    // Reset asserted while the wait-state instance is in WAIT.
    @(negedge clk);
    addr = 16'h0012; we = 1'b0; req3 = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0; req3 = 1'b0;
    #1;
    chk("rstwait_ack", {31'd0, ack3}, 0);
    chk("rstwait_exc", {31'd0, exc3}, 0);
    chk("rstwait_en", {31'd0, en3}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ack3 || en3 || exc3) acks++;
    end
    $display("after reset in WAIT: stray activity=%0d", acks);
    chk("rstwait_stray", acks, 0);
    v = '{1'b0, 16'h0012, 8'h00, 1'b0, 16'h0000, 2'b11, 1'b0, 5, 16'hA5A5};
    run_req(1'b1, v, 1'b0, lat, exc, rdat, en_cnt, en_addr, en_mask, en_we, both);
    $display("ws3 read after reset: lat=%0d rdata=%h", lat, rdat);
    chk("rstwait_relat", lat, 5);
    chk("rstwait_redata", {16'd0, rdat}, 32'hA5A5);

    // Reset asserted in the ack cycle must drop ack at once.
    @(negedge clk);
    addr = 16'h0012; we = 1'b0; req0 = 1'b1;
    @(negedge clk);
    chk("rstack_en", {31'd0, en0}, 1);
    @(negedge clk);
    chk("rstack_pre", {31'd0, ack0}, 1);
    rst_n = 1'b0; req0 = 1'b0;
    #1;
    $display("reset in ack cycle: ack=%0b data=%h", ack0, md0);
    chk("rstack_ack", {31'd0, ack0}, 0);
    chk("rstack_data", {16'd0, md0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
